stopwatch_timer: RTL and testbench
==================================

// Module: stopwatch_timer
// PURPOSE
//  Parametrised pure-RTL stopwatch/countdown timer that drives NUM_DIGITS seven-segment displays.
//  Counts BCD time (centiseconds, seconds, minutes, hours, low digit first).
//  Modes: count-up, count-down, lap, and auto-reload countdown.
//  Sits between board switches/keys and the HEX displays; needs no soft processor.
// PARAMETERS
//  CLK_HZ          50_000_000  input clock frequency
//  TICK_HZ         100         count rate; TICK_DIV = CLK_HZ/TICK_HZ, must be >= 2
//  NUM_DIGITS      6           displayed digits, 2..8; digit radices from pkg RADIX = {10,10,10,6,10,6,10,10}
//  SEG_ACTIVE_LOW  1           1: segment on = 0
//  BTN_ACTIVE_LOW  1           1: raw key pressed = 0
//  DEBOUNCE_MS     10          stable time required before a press is accepted (DEBOUNCE_EN only)
// PORTS
//  clk          in   1              single clock; all logic on its rising edge
//  reset        in   1              synchronous, active-high
//  mode         in   2              00 up, 01 down, 10 lap, 11 down-reload (switch level)
//  pause        in   1              switch level; 1 freezes counting
//  play_btn     in   1              raw key: start/stop (modes 00, 01, 11); lap toggle (mode 10)
//  clear_btn    in   1              raw key: return to IDLE
//  preset       in   4*NUM_DIGITS   BCD countdown start value
//  disp         out  NUM_DIGITS x 7 segments {g..a} per digit; disp[0] = least significant digit
//  running      out  1              state == RUN and pause == 0
//  done         out  1              level in DONE (mode 01); 1-cycle pulse on reload or up-wrap
// BEHAVIOUR
//  Reset: state = IDLE, count = 0, prescaler = 0, lap latch off, running = 0, done = 0,
//    every disp digit shows '0'.
//  Inputs: pause and mode pass through a 2-FF synchroniser.
//    Buttons pass through btn_conditioner, which outputs a 1-cycle press pulse.
//  States: IDLE, RUN, STOP, DONE.
//    IDLE: count = 0 for modes 00/10; count = preset for modes 01/11.
//      Preset digits above radix-1 are clamped to radix-1.
//    IDLE -play-> RUN.
//    RUN  -play-> STOP (modes 00/01/11).
//    STOP -play-> RUN.
//    Any state -clear-> IDLE.
//    A change in synced mode forces IDLE.
//    clear and play in the same cycle: clear wins.
//  Prescaler: counts 0..TICK_DIV-1 and only advances in RUN with pause == 0.
//    It is zeroed on entry to RUN, so the first tick comes TICK_DIV cycles after entry.
//    pause holds the prescaler; it is not reset.
//  Tick arithmetic: the whole carry/borrow chain resolves in the same cycle.
//    Up, digit i at RADIX[i]-1: wraps to 0 and carries.
//    Down, digit i at 0: becomes RADIX[i]-1 and borrows.
//  Up, all digits at max (e.g. 59:59.99): wraps to 0, done pulses, count continues.
//  Down, count reaches 0 in mode 01: count holds at 0, state -> DONE, done = 1.
//    DONE is left only by clear or a mode change.
//  Down, count reaches 0 in mode 11: on the next tick, count = preset and done pulses; stays in RUN.
//  Down started with preset = 0: mode 01 goes to DONE on the first tick.
//    Mode 11 reloads 0 and pulses done every tick.
//  Lap (mode 10): play toggles the lap latch while in RUN; count continues regardless.
//    Latch on: disp frozen at the value captured on the press.
//    Latch off: disp follows the live count.
//    From IDLE, play starts RUN; the latch starts off.
//  disp is registered: 1-cycle latency from a count change.
//  Segment polarity follows SEG_ACTIVE_LOW.
// CONFIGURATION
//  `define STOPWATCH_DEBOUNCE_EN
//    Defined: a press is accepted after the synced input is stable for
//      DEBOUNCE_MS*CLK_HZ/1000 cycles; the pulse comes on the accepted press edge.
//    Undefined: 2-FF synchroniser plus edge detect only; pulse 3 cycles after the raw edge.
// STRUCTURE
//  Package stopwatch_pkg:
//    state_t enum {IDLE, RUN, STOP, DONE}
//    mode_t enum {UP, DOWN, LAP, RELOAD}
//    RADIX constant array
//    function seg7(bcd) -> 7-bit active-high pattern
//  Sub-module btn_conditioner: parameters CLK_HZ, DEBOUNCE_MS, ACTIVE_LOW.
//    Ports clk, reset, raw, press (1-cycle pulse). Instantiated twice.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> TICK_DIV=10, NUM_DIGITS=6, debounce off)
//  Reset, no stimulus -> all digits 7'b1000000, running = 0, done = 0.
//  Mode 00, press play, wait 1000 cycles -> count 00:01.00; pause=1 for 200 cycles -> value unchanged;
//    press play -> STOP, count holds.
//  Mode 01, preset = 00:00.03, press play -> 3 ticks later count = 0, done stays 1;
//    play ignored; clear -> IDLE with count = 00:00.03.
//  Mode 11, preset = 00:00.02 -> done pulses every 3 ticks; count cycles 2,1,0,2.
//  Mode 10 running: play at count 00:00.50 -> disp frozen at 00:00.50 while the count advances;
//    play again -> disp shows the live count.
//  Mode 00 with count forced to 59:59.99 -> next tick count = 0 and done pulses 1 cycle;
//    clear and play in the same cycle -> IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types, digit radices and the seven-segment encoder
// used by the stopwatch/countdown timer.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP, DONE} state_t;
  typedef enum logic [1:0] {UP, DOWN, LAP, RELOAD} mode_t;

  localparam int MAX_DIGITS = 8;

  // Radix of each display digit, least significant first:
  // centiseconds (10,10), seconds (10,6), minutes (10,6), hours (10,10).
  localparam int RADIX [MAX_DIGITS] = '{10, 10, 10, 6, 10, 6, 10, 10};

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_timer_btn_conditioner.sv
// btn_conditioner: turns a raw board key into a single-cycle press pulse.
// Build option STOPWATCH_DEBOUNCE_EN: when defined, the synchronised key must
// hold its new level for DEBOUNCE_MS*CLK_HZ/1000 cycles before a press is
// accepted; when undefined, the pulse follows the raw edge by three cycles.
module btn_conditioner #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_press
);

  logic w_pressedRaw;
  logic r_sync1;
  logic r_sync2;
  logic r_press;

  assign w_pressedRaw = ACTIVE_LOW ? ~i_raw : i_raw;

  // Two-flop synchroniser; the key is normalised so that 1 always means pressed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_pressedRaw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam longint DB_RAW    = longint'(DEBOUNCE_MS) * longint'(CLK_HZ) / 1000;
  localparam int     DB_CYCLES = (DB_RAW < 1) ? 1 : int'(DB_RAW);
  localparam int     CW        = $clog2(DB_CYCLES + 1);

  logic          r_stable;
  logic [CW-1:0] r_dbCount;

  // Accept a new level only after it has persisted for the full debounce window.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stable  <= 1'b0;
      r_dbCount <= '0;
      r_press   <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_dbCount <= '0;
      end else if (r_dbCount == CW'(DB_CYCLES - 1)) begin
        r_stable  <= r_sync2;
        r_dbCount <= '0;
        r_press   <= r_sync2;
      end else begin
        r_dbCount <= r_dbCount + CW'(1);
      end
    end
  end
`else
  logic r_prev;

  // Rising-edge detect on the synchronised key, registered into a one-cycle pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_prev  <= r_sync2;
      r_press <= r_sync2 & ~r_prev;
    end
  end
`endif

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: BCD stopwatch / countdown timer driving NUM_DIGITS
// seven-segment displays. Modes: count-up, count-down, lap and auto-reload
// countdown. Key debouncing is selected by STOPWATCH_DEBOUNCE_EN (see
// btn_conditioner).
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 100,
  parameter int NUM_DIGITS     = 6,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_MS    = 10
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [1:0]                 i_mode,
  input  logic                       i_pause,
  input  logic                       i_play_btn,
  input  logic                       i_clear_btn,
  input  logic [4*NUM_DIGITS-1:0]    i_preset,
  output logic [NUM_DIGITS-1:0][6:0] o_disp,
  output logic                       o_running,
  output logic                       o_done
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);

  logic                       w_playPress;
  logic                       w_clearPress;
  logic [1:0]                 r_modeSync1;
  logic [1:0]                 r_modeSync2;
  logic [1:0]                 r_modePrev;
  logic                       r_pauseSync1;
  logic                       r_pauseSync2;
  mode_t                      w_mode;
  logic                       w_modeChange;
  state_t                     r_state;
  logic [NUM_DIGITS-1:0][3:0] r_count;
  logic [NUM_DIGITS-1:0][3:0] r_lapCount;
  logic                       r_lapOn;
  logic [PW-1:0]              r_presc;
  logic                       r_done;
  logic [NUM_DIGITS-1:0][6:0] r_disp;
  logic [NUM_DIGITS-1:0][3:0] w_preset;
  logic [NUM_DIGITS-1:0][3:0] w_countUp;
  logic [NUM_DIGITS-1:0][3:0] w_countDown;
  logic                       w_upWrap;
  logic                       w_downBorrow;
  logic                       w_countZero;
  logic                       w_downZero;
  logic                       w_presetMode;
  logic                       w_tick;

  function automatic logic [6:0] segOut(input logic [3:0] bcd);
    segOut = SEG_ACTIVE_LOW ? ~seg7(bcd) : seg7(bcd);
  endfunction

  btn_conditioner #(
    .CLK_HZ     (CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_playBtn (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_raw  (i_play_btn),
    .o_press(w_playPress)
  );

  btn_conditioner #(
    .CLK_HZ     (CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_clearBtn (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_raw  (i_clear_btn),
    .o_press(w_clearPress)
  );

  // Synchronise the switch levels and remember the previous mode to spot changes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_modeSync1  <= 2'b00;
      r_modeSync2  <= 2'b00;
      r_modePrev   <= 2'b00;
      r_pauseSync1 <= 1'b0;
      r_pauseSync2 <= 1'b0;
    end else begin
      r_modeSync1  <= i_mode;
      r_modeSync2  <= r_modeSync1;
      r_modePrev   <= r_modeSync2;
      r_pauseSync1 <= i_pause;
      r_pauseSync2 <= r_pauseSync1;
    end
  end

  assign w_mode       = mode_t'(r_modeSync2);
  assign w_modeChange = (r_modeSync2 != r_modePrev);
  assign w_presetMode = (w_mode == DOWN) || (w_mode == RELOAD);
  assign w_tick       = (r_state == RUN) && !r_pauseSync2 && (r_presc == PW'(TICK_DIV - 1));

  // Clamp each preset digit to the largest value its position can hold.
  always_comb begin
    w_preset = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i_preset[4*i +: 4] > 4'(RADIX[i] - 1)) w_preset[i] = 4'(RADIX[i] - 1);
      else                                       w_preset[i] = i_preset[4*i +: 4];
    end
  end

  // Full ripple of carry (up) and borrow (down) across all digits in one cycle.
  always_comb begin
    w_countUp    = r_count;
    w_countDown  = r_count;
    w_upWrap     = 1'b1;
    w_downBorrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_upWrap) begin
        if (r_count[i] == 4'(RADIX[i] - 1)) begin
          w_countUp[i] = 4'd0;
        end else begin
          w_countUp[i] = r_count[i] + 4'd1;
          w_upWrap     = 1'b0;
        end
      end
      if (w_downBorrow) begin
        if (r_count[i] == 4'd0) begin
          w_countDown[i] = 4'(RADIX[i] - 1);
        end else begin
          w_countDown[i] = r_count[i] - 4'd1;
          w_downBorrow   = 1'b0;
        end
      end
    end
  end

  assign w_countZero = (r_count == '0);
  assign w_downZero  = (w_countDown == '0);

  // Main control: state, count, prescaler, lap latch and the done flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_lapCount <= '0;
      r_lapOn    <= 1'b0;
      r_presc    <= '0;
      r_done     <= 1'b0;
    end else if (w_clearPress || w_modeChange) begin
      r_state <= IDLE;
      r_lapOn <= 1'b0;
      r_presc <= '0;
      r_done  <= 1'b0;
      r_count <= w_presetMode ? w_preset : '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_count <= w_presetMode ? w_preset : '0;
          r_lapOn <= 1'b0;
          if (w_playPress) begin
            r_state <= RUN;
            r_presc <= '0;
          end
        end
        RUN: begin
          if (w_playPress && (w_mode != LAP)) begin
            r_state <= STOP;
          end else begin
            if (w_playPress) begin
              r_lapOn <= !r_lapOn;
              if (!r_lapOn) r_lapCount <= r_count;
            end
            if (!r_pauseSync2) begin
              if (w_tick) begin
                r_presc <= '0;
                case (w_mode)
                  UP, LAP: begin
                    r_count <= w_countUp;
                    r_done  <= w_upWrap;
                  end
                  DOWN: begin
                    if (w_countZero || w_downZero) begin
                      r_count <= '0;
                      r_state <= DONE;
                      r_done  <= 1'b1;
                    end else begin
                      r_count <= w_countDown;
                    end
                  end
                  RELOAD: begin
                    if (w_countZero) begin
                      r_count <= w_preset;
                      r_done  <= 1'b1;
                    end else begin
                      r_count <= w_countDown;
                    end
                  end
                endcase
              end else begin
                r_presc <= r_presc + PW'(1);
              end
            end
          end
        end
        STOP: begin
          if (w_playPress) begin
            r_state <= RUN;
            r_presc <= '0;
          end
        end
        DONE: begin
          r_done <= 1'b1;
        end
      endcase
    end
  end

  // Registered segment drive: the frozen lap value while the latch is on, else the live count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_disp[i] <= segOut(4'd0);
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) r_disp[i] <= segOut(r_lapOn ? r_lapCount[i] : r_count[i]);
    end
  end

  assign o_disp    = r_disp;
  assign o_running = (r_state == RUN) && !r_pauseSync2;
  assign o_done    = r_done;

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: self-checking bench for stopwatch_timer with a
// 1 kHz clock, 100 Hz tick, six digits and debouncing disabled.
module tb_stopwatch_timer;

  localparam int TB_RADIX [6] = '{10, 10, 10, 6, 10, 6};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      mode = 2'b00;
  logic            pause = 1'b0;
  logic            playBtn = 1'b1;
  logic            clearBtn = 1'b1;
  logic [23:0]     preset = 24'h0;
  logic [5:0][6:0] disp;
  logic            running;
  logic            done;

  int          checks = 0;
  int          errors = 0;
  int          doneHigh = 0;
  logic [23:0] expQ [$];
  logic [23:0] lastExp = 24'h0;
  logic [23:0] model;

  always #5 clk = ~clk;

  stopwatch_timer #(
    .CLK_HZ        (1000),
    .TICK_HZ       (100),
    .NUM_DIGITS    (6),
    .SEG_ACTIVE_LOW(1'b1),
    .BTN_ACTIVE_LOW(1'b1),
    .DEBOUNCE_MS   (10)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_mode     (mode),
    .i_pause    (pause),
    .i_play_btn (playBtn),
    .i_clear_btn(clearBtn),
    .i_preset   (preset),
    .o_disp     (disp),
    .o_running  (running),
    .o_done     (done)
  );

  // Reference segment table {g..a}, active high.
  function automatic logic [6:0] tbSeg(input logic [3:0] d);
    case (d)
      4'd0: tbSeg = 7'h3F;
      4'd1: tbSeg = 7'h06;
      4'd2: tbSeg = 7'h5B;
      4'd3: tbSeg = 7'h4F;
      4'd4: tbSeg = 7'h66;
      4'd5: tbSeg = 7'h6D;
      4'd6: tbSeg = 7'h7D;
      4'd7: tbSeg = 7'h07;
      4'd8: tbSeg = 7'h7F;
      4'd9: tbSeg = 7'h6F;
      default: tbSeg = 7'h00;
    endcase
  endfunction

  // Active-low display image expected for a six-digit BCD value.
  function automatic logic [41:0] expDisp(input logic [23:0] bcd);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = ~tbSeg(bcd[4*i +: 4]);
    return r;
  endfunction

  // Reference BCD increment with per-digit radix and full wrap.
  function automatic logic [23:0] bcdInc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'(TB_RADIX[i] - 1)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold the selected raw keys low for five cycles, then release them.
  task automatic applyStimulus(input bit play, input bit clear);
    @(negedge clk);
    if (play)  playBtn = 1'b0;
    if (clear) clearBtn = 1'b0;
    repeat (5) @(negedge clk);
    playBtn = 1'b1;
    clearBtn = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every display change pops the next expected value; with the queue empty
  // any change must still equal the last expected value.
  task automatic runScoreboard(input string tag, input int cycles);
    logic [41:0] prevDisp;
    logic [23:0] e;
    prevDisp = disp;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done) doneHigh++;
      if (disp !== prevDisp) begin
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          lastExp = e;
        end else begin
          e = lastExp;
        end
        checkOutput(tag, 64'(disp), 64'(expDisp(e)));
        prevDisp = disp;
      end
    end
    checkOutput({tag, "Drain"}, 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("resetDisp", 64'(disp), 64'(expDisp(24'h0)));
    checkOutput("resetRunning", 64'(running), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);

    // Count up for one second, then pause and stop.
    model = 24'h0;
    for (int k = 0; k < 100; k++) begin
      model = bcdInc(model);
      expQ.push_back(model);
    end
    applyStimulus(1'b1, 1'b0);
    runScoreboard("up", 1000);
    checkOutput("upOneSec", 64'(disp), 64'(expDisp(24'h000100)));
    pause = 1'b1;
    runScoreboard("pauseHold", 200);
    checkOutput("pauseRunning", 64'(running), 64'd0);
    pause = 1'b0;
    applyStimulus(1'b1, 1'b0);
    runScoreboard("stopHold", 100);
    checkOutput("stopDisp", 64'(disp), 64'(expDisp(24'h000100)));
    checkOutput("stopRunning", 64'(running), 64'd0);

    // Countdown from 00:00.03 into DONE.
    applyStimulus(1'b0, 1'b1);
    mode = 2'b01;
    preset = 24'h000003;
    waitCycles(5);
    checkOutput("downIdle", 64'(disp), 64'(expDisp(24'h000003)));
    expQ.push_back(24'h000002);
    expQ.push_back(24'h000001);
    expQ.push_back(24'h000000);
    applyStimulus(1'b1, 1'b0);
    runScoreboard("down", 40);
    checkOutput("downDoneLevel", 64'(done), 64'd1);
    checkOutput("downHalted", 64'(running), 64'd0);
    applyStimulus(1'b1, 1'b0);
    runScoreboard("doneHold", 20);
    checkOutput("doneIgnorePlay", 64'(done), 64'd1);
    checkOutput("doneNotRunning", 64'(running), 64'd0);
    applyStimulus(1'b0, 1'b1);
    waitCycles(2);
    checkOutput("clearPreset", 64'(disp), 64'(expDisp(24'h000003)));
    checkOutput("clearDone", 64'(done), 64'd0);
    preset = 24'h0070F0;
    waitCycles(2);
    checkOutput("presetClamp", 64'(disp), 64'(expDisp(24'h005090)));

    // Auto-reload countdown from 00:00.02.
    mode = 2'b11;
    preset = 24'h000002;
    waitCycles(5);
    checkOutput("reloadIdle", 64'(disp), 64'(expDisp(24'h000002)));
    for (int k = 0; k < 3; k++) begin
      expQ.push_back(24'h000001);
      expQ.push_back(24'h000000);
      expQ.push_back(24'h000002);
    end
    doneHigh = 0;
    applyStimulus(1'b1, 1'b0);
    runScoreboard("reload", 95);
    checkOutput("reloadPulses", 64'(doneHigh), 64'd3);

    // Lap: freeze at 00:00.50, release later onto the live count.
    mode = 2'b10;
    waitCycles(5);
    checkOutput("lapIdle", 64'(disp), 64'(expDisp(24'h0)));
    model = 24'h0;
    for (int k = 0; k < 50; k++) begin
      model = bcdInc(model);
      expQ.push_back(model);
    end
    applyStimulus(1'b1, 1'b0);
    runScoreboard("lapLive", 500);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lapLatch", 64'(disp), 64'(expDisp(24'h000050)));
    runScoreboard("lapFrozen", 100);
    checkOutput("lapRunning", 64'(running), 64'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lapRelease", 64'(disp), 64'(expDisp(24'h000061)));
    expQ.push_back(24'h000062);
    expQ.push_back(24'h000063);
    runScoreboard("lapResume", 20);

    // Up-count wrap from 59:59.99, then clear and play together.
    mode = 2'b00;
    waitCycles(5);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    dut.r_count = 24'h595999;
    waitCycles(2);
    checkOutput("wrapForced", 64'(disp), 64'(expDisp(24'h595999)));
    model = bcdInc(24'h595999);
    expQ.push_back(model);
    expQ.push_back(bcdInc(model));
    doneHigh = 0;
    applyStimulus(1'b1, 1'b0);
    runScoreboard("wrap", 20);
    checkOutput("wrapPulse", 64'(doneHigh), 64'd1);
    checkOutput("wrapRunning", 64'(running), 64'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("clearWinsDisp", 64'(disp), 64'(expDisp(24'h0)));
    checkOutput("clearWinsRunning", 64'(running), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
